// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU subsystem: bus sizing defaults and the
// result transmitter state encoding.
package alu_sys_pkg;

    localparam int ALU_DATA_WIDTH = 8;
    localparam int ALU_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2
    } tx_state_e;

    // Byte lane selected for a given state; IDLE drives zero.
    function automatic logic [ALU_DATA_WIDTH-1:0] tx_byte(
        input tx_state_e                     st,
        input logic [2*ALU_DATA_WIDTH-1:0]   word
    );
        logic [ALU_DATA_WIDTH-1:0] b;
        b = '0;
        if (st == ST_SEND_LO) begin
            b = word[ALU_DATA_WIDTH-1:0];
        end else if (st == ST_SEND_HI) begin
            b = word[2*ALU_DATA_WIDTH-1:ALU_DATA_WIDTH];
        end
        return b;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO for ALU results. Head is read combinationally so
// the consumer can load it on the same edge it pops.
module result_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic [PTR_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 drop
);

    localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 full_q, full_d;
    logic                 wr_ok, rd_ok;

    // Fullness uses the start-of-cycle count: a same-cycle pop does not
    // make room for a write.
    assign wr_ok = wr_en && !full_q;
    assign rd_ok = rd_en && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign drop    = wr_en && full_q;

endmodule

// File: rtl/alu_result_tx.sv
// Buffers ALU results and streams each one out as two bytes, LSB first,
// over a valid/ready link; flags results lost to a full buffer.
module alu_result_tx
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int DEPTH      = ALU_FIFO_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    FIFO_FULL,
    output logic                    OVERFLOW,
    input  logic                    CLR_OVF
);

    logic [2*DATA_WIDTH-1:0] fifo_rd_data;
    logic [PTR_WIDTH:0]      fifo_count;
    logic                    fifo_full, fifo_empty, fifo_drop;
    logic                    pop;

    tx_state_e               state_q, state_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    ovf_q, ovf_d;

    result_fifo #(
        .WIDTH     (2*DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (ALU_OUT_VALID),
        .wr_data (ALU_OUT),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    hold_d  = fifo_rd_data;
                    pop     = 1'b1;
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (TX_READY) begin
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                // Chain straight into the next result to keep the link busy.
                if (TX_READY) begin
                    if (fifo_count != '0) begin
                        hold_d  = fifo_rd_data;
                        pop     = 1'b1;
                        state_d = ST_SEND_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state will present.
        tx_valid_d = (state_d != ST_IDLE);
        tx_data_d  = tx_byte(state_d, hold_d);

        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign FIFO_FULL = fifo_full;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: latency, back-pressure, overflow,
// back-to-back chaining, set/clear priority and asynchronous reset.
module tb_alu_result_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VALID = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic        FIFO_FULL;
    logic        OVERFLOW;
    logic        CLR_OVF = 1'b0;

    int total = 0;
    int bad   = 0;
    int accepted = 0;
    int acc_base;

    alu_result_tx dut (
        .CLK           (CLK),
        .RST           (RST),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .TX_DATA       (TX_DATA),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY),
        .FIFO_FULL     (FIFO_FULL),
        .OVERFLOW      (OVERFLOW),
        .CLR_OVF       (CLR_OVF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (TX_VALID && TX_READY) accepted <= accepted + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {15'd0, TX_VALID}, 16'd1);
        check({tag, "_data"}, {8'd0, TX_DATA}, {8'd0, exp});
    endtask

    initial begin
        logic [7:0] drain_exp;

        // Reset state
        tick();
        tick();
        check("rst_valid", {15'd0, TX_VALID}, 16'd0);
        check("rst_data", {8'd0, TX_DATA}, 16'd0);
        check("rst_full", {15'd0, FIFO_FULL}, 16'd0);
        check("rst_ovf", {15'd0, OVERFLOW}, 16'd0);
        RST = 1'b1;
        tick();

        // Single result, ready high
        TX_READY = 1'b1;
        ALU_OUT = 16'hA5C3; ALU_OUT_VALID = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0; ALU_OUT = 16'hFFFF;
        check("single_k", {15'd0, TX_VALID}, 16'd0);
        tick();
        check_byte("single_lo", 8'hC3);
        tick();
        check_byte("single_hi", 8'hA5);
        tick();
        check("single_end", {15'd0, TX_VALID}, 16'd0);

        // Back-pressure
        TX_READY = 1'b0;
        acc_base = accepted;
        ALU_OUT = 16'h1234; ALU_OUT_VALID = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0;
        tick();
        check_byte("bp_first", 8'h34);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_byte("bp_stall", 8'h34);
        end
        TX_READY = 1'b1;
        tick();
        check_byte("bp_hi", 8'h12);
        tick();
        check("bp_end", {15'd0, TX_VALID}, 16'd0);
        check("bp_count", 16'(accepted - acc_base), 16'd2);

        // Overflow and drain order
        TX_READY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ALU_OUT = 16'(i); ALU_OUT_VALID = 1'b1;
            tick();
            if (i == 4) check("ovf_notfull4", {15'd0, FIFO_FULL}, 16'd0);
        end
        check("ovf_full5", {15'd0, FIFO_FULL}, 16'd1);
        check("ovf_clear5", {15'd0, OVERFLOW}, 16'd0);
        ALU_OUT = 16'h0006;
        tick();
        ALU_OUT_VALID = 1'b0;
        check("ovf_set", {15'd0, OVERFLOW}, 16'd1);
        check("ovf_still_full", {15'd0, FIFO_FULL}, 16'd1);
        TX_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drain_exp = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00;
            check_byte("drain", drain_exp);
            tick();
        end
        check("drain_end", {15'd0, TX_VALID}, 16'd0);
        check("drain_notfull", {15'd0, FIFO_FULL}, 16'd0);
        check("ovf_sticky", {15'd0, OVERFLOW}, 16'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("ovf_cleared", {15'd0, OVERFLOW}, 16'd0);

        // Back-to-back
        TX_READY = 1'b1;
        ALU_OUT = 16'hBEEF; ALU_OUT_VALID = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0;
        tick();
        check_byte("b2b_0", 8'hEF);
        ALU_OUT = 16'hCAFE; ALU_OUT_VALID = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0;
        check_byte("b2b_1", 8'hBE);
        tick();
        check_byte("b2b_2", 8'hFE);
        tick();
        check_byte("b2b_3", 8'hCA);
        tick();
        check("b2b_end", {15'd0, TX_VALID}, 16'd0);

        // Simultaneous set/clear
        TX_READY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ALU_OUT = {8'hA0 + 8'(i), 8'hB0 + 8'(i)}; ALU_OUT_VALID = 1'b1;
            tick();
        end
        check("sc_full", {15'd0, FIFO_FULL}, 16'd1);
        ALU_OUT = 16'hDEAD; CLR_OVF = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0;
        check("sc_set_wins", {15'd0, OVERFLOW}, 16'd1);
        tick();
        CLR_OVF = 1'b0;
        check("sc_clear_alone", {15'd0, OVERFLOW}, 16'd0);

        // Advance into SEND_HI of the third result with two queued
        TX_READY = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        TX_READY = 1'b0;
        check_byte("pre_rst_hi", 8'hA3);
        check("pre_rst_notfull", {15'd0, FIFO_FULL}, 16'd0);

        // Asynchronous reset mid-operation
        #2;
        RST = 1'b0;
        #1;
        check("arst_valid", {15'd0, TX_VALID}, 16'd0);
        check("arst_data", {8'd0, TX_DATA}, 16'd0);
        check("arst_full", {15'd0, FIFO_FULL}, 16'd0);
        check("arst_ovf", {15'd0, OVERFLOW}, 16'd0);
        tick();
        RST = 1'b1;
        TX_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_quiet", {15'd0, TX_VALID}, 16'd0);
        end
        ALU_OUT = 16'h5AA5; ALU_OUT_VALID = 1'b1;
        tick();
        ALU_OUT_VALID = 1'b0;
        tick();
        check_byte("post_rst_lo", 8'hA5);
        tick();
        check_byte("post_rst_hi", 8'h5A);
        tick();
        check("post_rst_end", {15'd0, TX_VALID}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
